// File: rtl/apb_irq_ctrl_prio_pkg.sv
// apb_irq_ctrl_pkg: register map, control bits and FSM states for the APB interrupt controller
package apb_irq_ctrl_pkg;
    localparam logic [2:0] REG_MASK    = 3'd0;
    localparam logic [2:0] REG_PENDING = 3'd1;
    localparam logic [2:0] REG_SET     = 3'd2;
    localparam logic [2:0] REG_CLEAR   = 3'd3;
    localparam logic [2:0] REG_ID      = 3'd4;
    localparam logic [2:0] REG_CTRL    = 3'd5;
    localparam int CTRL_EN_BIT = 0;
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;
    function automatic logic reg_unmapped(input logic [2:0] idx);
        return idx > REG_CTRL;
    endfunction
endpackage

// File: rtl/apb_irq_ctrl_prio_if.sv
// apb_irq_ctrl_prio_if: APB slave bus bundle for the interrupt controller
interface apb_irq_ctrl_prio_if #(parameter int APB_ADDR_WIDTH = 12);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;
    modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PRDATA, PREADY, PSLVERR);
    modport slave  (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_irq_ctrl_prio_enc.sv
// irq_prio_enc: find-first-one encoder, lowest set index wins
module irq_prio_enc #(
    parameter int NB_LINES = 32,
    parameter int ID_WIDTH = 5
) (
    input  logic [NB_LINES-1:0] i_vec,
    output logic [ID_WIDTH-1:0] o_id,
    output logic                o_valid
);
    always_comb begin
        o_id = '0;
        for (int i = NB_LINES - 1; i >= 0; i--)
            o_id = i_vec[i] ? ID_WIDTH'(i) : o_id;
    end
    assign o_valid = |i_vec;
endmodule

// File: rtl/apb_irq_ctrl_prio.sv
// apb_irq_ctrl_prio: APB interrupt controller with edge-latched pending lines and fixed-priority request
module apb_irq_ctrl_prio
    import apb_irq_ctrl_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NB_LINES       = 32,
    parameter int ID_WIDTH       = 5
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    apb_irq_ctrl_prio_if.slave  apb,
    input  logic [NB_LINES-1:0] irq_i,
    output logic                irq_req_o,
    output logic [ID_WIDTH-1:0] irq_id_o,
    input  logic                irq_ack_i,
    output logic                wake_o
);
    logic [NB_LINES-1:0] r_mask, r_pending, r_irq_q;
    logic [NB_LINES-1:0] w_rise, w_wdata, w_pend_wr, w_ack_clr, w_pend_next, w_active;
    logic                r_enable, r_req, r_wake;
    logic [ID_WIDTH-1:0] r_id, w_enc_id;
    logic                w_enc_valid;
    state_e              r_state;
    logic [2:0]          w_idx;
    logic                w_err, w_access, w_wr, w_unused;
    logic [31:0]         w_rdata;

    assign w_idx    = apb.PADDR[4:2];
    assign w_err    = (|apb.PADDR[APB_ADDR_WIDTH-1:5]) | reg_unmapped(w_idx);
    assign w_access = apb.PSEL & apb.PENABLE;
    assign w_wr     = w_access & apb.PWRITE & ~w_err;
    assign w_wdata  = apb.PWDATA[NB_LINES-1:0];
    assign w_unused = &{1'b0, apb.PADDR[1:0], apb.PWDATA};
    assign w_rise   = irq_i & ~r_irq_q;
    assign w_active = r_pending & r_mask;

    // write, then ack clear, then new edges: a fresh edge always survives
    assign w_pend_wr = !w_wr                  ? r_pending :
                       w_idx == REG_PENDING   ? w_wdata :
                       w_idx == REG_SET       ? r_pending | w_wdata :
                       w_idx == REG_CLEAR     ? r_pending & ~w_wdata : r_pending;
    assign w_ack_clr   = (r_state == REQ && irq_ack_i) ? (NB_LINES'(1) << r_id) : '0;
    assign w_pend_next = (w_pend_wr & ~w_ack_clr) | w_rise;

    always_comb begin
        w_rdata = w_idx == REG_MASK    ? 32'(r_mask) :
                  w_idx == REG_PENDING ? 32'(r_pending) :
                  w_idx == REG_ID      ? {r_req, {(31-ID_WIDTH){1'b0}}, r_id} :
                  w_idx == REG_CTRL    ? 32'(r_enable) : '0;
    end

    assign apb.PRDATA  = (apb.PSEL & ~w_err) ? w_rdata : '0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = w_access & w_err;

    irq_prio_enc #(.NB_LINES(NB_LINES), .ID_WIDTH(ID_WIDTH)) u_enc (
        .i_vec   (w_active),
        .o_id    (w_enc_id),
        .o_valid (w_enc_valid)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_mask    <= '0;
            r_pending <= '0;
            r_irq_q   <= '0;
            r_enable  <= 1'b0;
            r_wake    <= 1'b0;
        end else begin
            r_irq_q   <= irq_i;
            r_pending <= w_pend_next;
            r_wake    <= |w_active;
            if (w_wr && w_idx == REG_MASK) r_mask <= w_wdata;
            if (w_wr && w_idx == REG_CTRL) r_enable <= apb.PWDATA[CTRL_EN_BIT];
        end
    end

    // request and ID are frozen in REQ; only an ack releases them
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_id    <= '0;
        end else begin
            case (r_state)
                IDLE: if (r_enable && w_enc_valid) begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                    r_id    <= w_enc_id;
                end
                REQ: if (irq_ack_i) begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_o = r_req;
    assign irq_id_o  = r_id;
    assign wake_o    = r_wake;
endmodule

// File: tb/tb_apb_irq_ctrl_prio.sv
// tb_apb_irq_ctrl_prio: register vectors, directed corner sequences and random traffic against a reference model
module tb_apb_irq_ctrl_prio;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] irq = '0;
    logic        ack = 1'b0;
    logic        irq_req, wake, irq_req8, wake8;
    logic [4:0]  irq_id;
    logic [2:0]  irq_id8;

    apb_irq_ctrl_prio_if bus ();
    apb_irq_ctrl_prio_if bus8 ();

    always #5 HCLK = ~HCLK;

    apb_irq_ctrl_prio u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .apb(bus.slave), .irq_i(irq),
        .irq_req_o(irq_req), .irq_id_o(irq_id), .irq_ack_i(ack), .wake_o(wake)
    );

    apb_irq_ctrl_prio #(.NB_LINES(8), .ID_WIDTH(3)) u_dut8 (
        .HCLK(HCLK), .HRESETn(HRESETn), .apb(bus8.slave), .irq_i(8'h00),
        .irq_req_o(irq_req8), .irq_id_o(irq_id8), .irq_ack_i(1'b0), .wake_o(wake8)
    );

    int n_tests = 0;
    int n_fail = 0;
    bit [31:0] m_mask, m_pend, m_prev, n_mask, n_pend, n_prev;
    bit        m_en, n_en, m_req, n_req, m_wake, n_wake;
    int        m_id, n_id;
    logic [31:0] last_rd, last_rd8;
    logic        last_err;
    bit          rnd = 0;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } vec_t;
    vec_t vt [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        {m_mask, m_pend, m_prev, m_en, m_req, m_wake, m_id} = '0;
    endtask

    // reference: next state from the documented rules, evaluated with inputs stable before the edge
    task automatic model_eval();
        bit acc, err, found;
        int idx;
        bit [31:0] exp_rd;
        acc = bus.PSEL && bus.PENABLE;
        idx = int'(bus.PADDR[4:2]);
        err = (bus.PADDR[11:5] != 0) || idx > 5;
        n_mask = m_mask; n_pend = m_pend; n_en = m_en; n_req = m_req; n_id = m_id; n_prev = irq;
        if (acc) begin
            chk("pslverr", bus.PSLVERR, err);
            if (!bus.PWRITE) begin
                exp_rd = err ? 0 : idx == 0 ? m_mask : idx == 1 ? m_pend :
                         idx == 4 ? (m_req ? (32'h8000_0000 | 32'(m_id)) : 0) : idx == 5 ? 32'(m_en) : 0;
                if (idx == 4 && !m_req && !err) chk("prdata_id", bus.PRDATA & 32'hFFFF_FFE0, 0);
                else chk("prdata", bus.PRDATA, exp_rd);
            end else if (!err) begin
                case (idx)
                    0: n_mask = bus.PWDATA;
                    1: n_pend = bus.PWDATA;
                    2: n_pend = n_pend | bus.PWDATA;
                    3: n_pend = n_pend & ~bus.PWDATA;
                    5: n_en = bus.PWDATA[0];
                    default: ;
                endcase
            end
        end
        if (m_req && ack) n_pend[m_id] = 1'b0;
        n_pend = n_pend | (irq & ~m_prev);
        n_wake = (m_pend & m_mask) != 0;
        if (!m_req) begin
            found = 0;
            for (int i = 0; i < 32; i++)
                if (!found && m_en && m_pend[i] && m_mask[i]) begin
                    found = 1; n_req = 1; n_id = i;
                end
        end else if (ack) n_req = 0;
    endtask

    task automatic cyc();
        if (rnd) begin
            irq = $urandom & $urandom & $urandom;
            ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        end
        @(negedge HCLK);
        model_eval();
        last_rd = bus.PRDATA; last_err = bus.PSLVERR; last_rd8 = bus8.PRDATA;
        @(posedge HCLK); #1;
        m_mask = n_mask; m_pend = n_pend; m_prev = n_prev; m_en = n_en;
        m_req = n_req; m_id = n_id; m_wake = n_wake;
        chk("req", irq_req, m_req);
        if (m_req) chk("id", irq_id, 32'(m_id));
        chk("wake", wake, m_wake);
    endtask

    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d);
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
        cyc();
        bus.PENABLE = 1;
        cyc();
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit rereq;
        logic [11:0] a;
        vt[0]  = '{0, 12'h000, 32'h0, 32'h0, 0};
        vt[1]  = '{0, 12'h010, 32'h0, 32'h0, 0};
        vt[2]  = '{1, 12'h000, 32'h5, 32'h0, 0};
        vt[3]  = '{0, 12'h000, 32'h0, 32'h5, 0};
        vt[4]  = '{1, 12'h004, 32'hF0, 32'h0, 0};
        vt[5]  = '{1, 12'h008, 32'h03, 32'h0, 0};
        vt[6]  = '{0, 12'h004, 32'h0, 32'hF3, 0};
        vt[7]  = '{0, 12'h008, 32'h0, 32'h0, 0};
        vt[8]  = '{1, 12'h00C, 32'h30, 32'h0, 0};
        vt[9]  = '{0, 12'h004, 32'h0, 32'hC3, 0};
        vt[10] = '{0, 12'h00C, 32'h0, 32'h0, 0};
        vt[11] = '{1, 12'h014, 32'hFFFF_FFFE, 32'h0, 0};
        vt[12] = '{0, 12'h014, 32'h0, 32'h0, 0};
        vt[13] = '{0, 12'h018, 32'h0, 32'h0, 1};
        vt[14] = '{1, 12'h01C, 32'hFF, 32'h0, 1};
        vt[15] = '{1, 12'h104, 32'h0, 32'h0, 1};
        vt[16] = '{0, 12'h004, 32'h0, 32'hC3, 0};
        vt[17] = '{0, 12'h020, 32'h0, 32'h0, 1};
        vt[18] = '{1, 12'h004, 32'h0, 32'h0, 0};
        vt[19] = '{1, 12'h000, 32'h0, 32'h0, 0};
        {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} = '0;
        {bus8.PSEL, bus8.PENABLE, bus8.PWRITE, bus8.PADDR, bus8.PWDATA} = '0;
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_req", irq_req, 0);
        chk("rst_id", irq_id, 0);
        chk("rst_wake", wake, 0);
        HRESETn = 1;

        for (int i = 0; i < 20; i++) begin
            apb(vt[i].wr, vt[i].addr, vt[i].wdata);
            chk("vec_err", last_err, vt[i].err);
            if (!vt[i].wr) chk("vec_rd", last_rd, vt[i].rdata);
        end

        // edge on line 2 -> request two cycles later, ack clears it
        apb(1, 12'h000, 32'h5); apb(1, 12'h014, 32'h1);
        irq = 32'h4; cyc();
        chk("t1_req_early", irq_req, 0);
        irq = 0; cyc();
        chk("t1_req", irq_req, 1); chk("t1_id", irq_id, 2);
        ack = 1; cyc(); ack = 0;
        chk("t1_req_ack", irq_req, 0);
        apb(0, 12'h004, 0);
        chk("t1_pending", last_rd, 0);

        // simultaneous edges on 7 and 3 -> 3 first, then 7 after one idle cycle
        apb(1, 12'h000, 32'hFF);
        irq = 32'h88; cyc(); irq = 0; cyc();
        chk("t2_req3", irq_req, 1); chk("t2_id3", irq_id, 3);
        ack = 1; cyc(); ack = 0;
        chk("t2_idle", irq_req, 0);
        cyc();
        chk("t2_req7", irq_req, 1); chk("t2_id7", irq_id, 7);
        ack = 1; cyc(); ack = 0;

        // level held high gives exactly one request
        irq = 32'h10; cyc(); cyc();
        chk("t3_req", irq_req, 1); chk("t3_id", irq_id, 4);
        ack = 1; cyc(); ack = 0;
        rereq = 0;
        repeat (7) begin cyc(); rereq |= irq_req; end
        chk("t3_no_rereq", rereq, 0);
        apb(0, 12'h004, 0);
        chk("t3_pending", last_rd, 0);
        irq = 0; cyc(); irq = 32'h10; cyc(); cyc();
        chk("t3_new_edge", irq_req, 1);
        irq = 0; ack = 1; cyc(); ack = 0;

        // edge coinciding with ack of the same line keeps it pending
        irq = 32'h8; cyc(); irq = 0; cyc();
        chk("t4_id", irq_id, 3);
        ack = 1; irq = 32'h8; cyc(); ack = 0; irq = 0;
        chk("t4_drop", irq_req, 0);
        cyc();
        chk("t4_rereq", irq_req, 1); chk("t4_reid", irq_id, 3);
        ack = 1; cyc(); ack = 0;

        // masking during a request does not retract it
        irq = 32'h2; cyc(); irq = 0; cyc();
        chk("t5_req", irq_req, 1); chk("t5_wake", wake, 1);
        apb(1, 12'h000, 32'h0);
        chk("t5_hold", irq_req, 1); chk("t5_hold_id", irq_id, 1);
        cyc();
        chk("t5_wake_off", wake, 0); chk("t5_still", irq_req, 1);
        ack = 1; cyc(); ack = 0;
        chk("t5_ack", irq_req, 0);

        // narrow instance: bits above NB_LINES read as zero
        bus8.PSEL = 1; bus8.PWRITE = 1; bus8.PADDR = 12'h004; bus8.PWDATA = 32'hFFFF_FFFF;
        cyc(); bus8.PENABLE = 1; cyc();
        bus8.PENABLE = 0; bus8.PWRITE = 0; cyc(); bus8.PENABLE = 1; cyc();
        chk("nb8_pending", last_rd8, 32'hFF);
        bus8.PSEL = 0; bus8.PENABLE = 0;
        apb(0, 12'h018, 0);
        chk("t6_err", last_err, 1); chk("t6_rd", last_rd, 0);

        // random traffic
        rnd = 1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 2) == 0) cyc();
            else begin
                a = {($urandom_range(0, 9) == 0) ? 7'($urandom_range(1, 127)) : 7'd0, 3'($urandom_range(0, 7)), 2'b00};
                apb(1'($urandom_range(0, 1)), a, $urandom & ($urandom_range(0, 1) ? 32'hFF : 32'hFFFF_FFFF));
            end
        end
        rnd = 0; irq = 0; ack = 0;
        cyc(); cyc();

        // asynchronous reset in the middle of a request
        apb(1, 12'h000, 32'hFF); apb(1, 12'h014, 32'h1);
        if (m_req) begin ack = 1; cyc(); ack = 0; end
        apb(1, 12'h004, 0);
        irq = 32'h1; cyc(); irq = 0; cyc();
        if (!m_req) cyc();
        chk("t6_req_pre", irq_req, 1);
        #3 HRESETn = 0;
        #1;
        chk("t6_rst_req", irq_req, 0);
        chk("t6_rst_id", irq_id, 0);
        chk("t6_rst_wake", wake, 0);
        model_reset();
        @(posedge HCLK); #1;
        HRESETn = 1;
        apb(0, 12'h004, 0);
        chk("t6_rst_pend", last_rd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
